pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles level_out is high per pulse; legal values are 1 or more.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, giving the minimum number of low cycles between consecutive high intervals; legal values are 1 or more.
REQ-003 The block SHALL have parameter PEND_MAX, default 7, giving the saturation value of the pending-pulse counter.
REQ-004 The block SHALL have parameter PEND_W, default 3, giving the width of pending; PEND_W SHALL be at least clog2(PEND_MAX+1).
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pulse_in  input  1  single-cycle event request; each cycle sampled high counts as one event.
REQ-008 clear_ovf  input  1  clears the overflow flag.
REQ-009 level_out  output  1  registered stretched level, one high interval per accepted event.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 pending  output  PEND_W  number of accepted events not yet launched.
REQ-012 overflow  output  1  sticky flag indicating at least one event was dropped.

Function
REQ-013 The FSM SHALL have three states: IDLE, HOLD and GAP; level_out SHALL be high exactly when the state is HOLD.
REQ-014 A launch SHALL occur at an edge when the state is IDLE, or when the state is GAP on its final (GAP_CYCLES-th) cycle, and in either case pulse_in=1 or pending>0.
REQ-015 On a launch, the state SHALL go to HOLD and the timer SHALL load; HOLD SHALL last exactly HOLD_CYCLES cycles, after which the state goes to GAP.
REQ-016 GAP SHALL last exactly GAP_CYCLES cycles; at its final cycle the block SHALL launch if REQ-014 holds, otherwise go to IDLE.
REQ-017 Latency: with the state IDLE, pending=0 and pulse_in high in cycle k, level_out SHALL be high in cycles k+1 through k+HOLD_CYCLES.
REQ-018 Pending update per edge SHALL be pending + arrival - launch, where arrival = pulse_in, clipped to the range 0..PEND_MAX.
REQ-019 When a launch coincides with pulse_in, pending SHALL stay unchanged; when pending=0, the arriving event SHALL be consumed directly.
REQ-020 When arrival=1, there is no launch and pending=PEND_MAX, the event SHALL be dropped, pending SHALL stay at PEND_MAX with no wrap, and overflow SHALL be set.
REQ-021 overflow SHALL be cleared by clear_ovf; if clear_ovf coincides with a drop event, the set SHALL win.
REQ-022 The repetition period for back-to-back events SHALL be exactly HOLD_CYCLES+GAP_CYCLES cycles.
REQ-023 busy SHALL be registered-equivalent, i.e. a decode of the state register only.
REQ-024 pulse_in held high for N cycles SHALL be treated as N events; there is no edge detection.

Reset
REQ-025 When reset is sampled high, the next state SHALL be IDLE, and level_out, busy, pending, overflow and the timer SHALL all be 0.
REQ-026 reset SHALL take priority over pulse_in and clear_ovf; events sampled during reset SHALL be discarded.
REQ-027 A reset mid-HOLD or mid-GAP SHALL abort the interval; level_out SHALL be 0 in the cycle after reset is sampled.

Verification (defaults HOLD=4, GAP=2, PEND_MAX=7)
REQ-028 Single pulse_in at cycle 10 from IDLE SHALL give level_out=1 in cycles 11-14 and 0 from cycle 15; busy SHALL be 1 in cycles 11-16 and 0 at cycle 17; pending SHALL stay 0 throughout.
REQ-029 pulse_in high in cycles 10, 11 and 12 SHALL give level_out high in cycles 11-14, 17-20 and 23-26; pending SHALL step 1, 2, 1, 0; overflow SHALL stay 0.
REQ-030 pulse_in held high for 20 cycles SHALL saturate pending at 7 with no wrap to 0, set overflow=1, and keep level_out pulsing at a 6-cycle period until pending=0.
REQ-031 With pending=0, a pulse_in in the last GAP cycle SHALL make level_out go high the next cycle with no intervening IDLE cycle (busy stays 1).
REQ-032 Reset asserted in the 2nd HOLD cycle with pending=3 and overflow=1 SHALL give level_out=0, busy=0, pending=0 and overflow=0 the next cycle.
REQ-033 clear_ovf coinciding with a drop SHALL leave overflow=1; clear_ovf alone on a later cycle SHALL give overflow=0 the next cycle.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle event requests into fixed-width high
// intervals separated by a minimum gap, queueing up to PEND_MAX excess events.
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_MAX    = 7,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              clear_ovf,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int T_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0]     HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]     T_ZERO    = {TW{1'b0}};
    localparam logic [PEND_W-1:0] PEND_SAT  = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]        r_state;
    logic [TW-1:0]     r_timer;
    logic [PEND_W-1:0] r_pending;
    logic              r_overflow;
    logic              r_level;

    logic              w_can_launch;
    logic              w_launch;
    logic              w_drop;
    logic [1:0]        w_state_nxt;
    logic [TW-1:0]     w_timer_nxt;
    logic [PEND_W:0]   w_pend_sum;
    logic [PEND_W-1:0] w_pend_nxt;
    logic              w_ovf_nxt;

    // A launch may happen from IDLE or on the last GAP cycle, given work to do.
    always_comb begin
        w_can_launch = (r_state == ST_IDLE) || ((r_state == ST_GAP) && (r_timer == T_ZERO));
        w_launch     = w_can_launch && (pulse_in || (r_pending != PEND_ZERO));
        w_drop       = pulse_in && !w_launch && (r_pending == PEND_SAT);
    end

    // Next state and interval timer; the timer counts down to zero in each phase.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        if (w_launch) begin
            w_state_nxt = ST_HOLD;
            w_timer_nxt = HOLD_LOAD;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_timer == T_ZERO) begin
                        w_state_nxt = ST_GAP;
                        w_timer_nxt = GAP_LOAD;
                    end else begin
                        w_timer_nxt = r_timer - {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                ST_GAP: begin
                    if (r_timer == T_ZERO) begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = T_ZERO;
                    end else begin
                        w_timer_nxt = r_timer - {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = T_ZERO;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = T_ZERO;
                end
            endcase
        end
    end

    // Pending count and sticky overflow; a drop keeps the count saturated and beats clear_ovf.
    always_comb begin
        w_pend_sum = {1'b0, r_pending} + {{PEND_W{1'b0}}, pulse_in}
                   - {{PEND_W{1'b0}}, w_launch};
        if (w_drop) begin
            w_pend_nxt = PEND_SAT;
        end else begin
            w_pend_nxt = w_pend_sum[PEND_W-1:0];
        end
        if (w_drop) begin
            w_ovf_nxt = 1'b1;
        end else if (clear_ovf) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_overflow;
        end
    end

    // State registers with synchronous reset; level_out is registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= T_ZERO;
            r_pending  <= PEND_ZERO;
            r_overflow <= 1'b0;
            r_level    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_pending  <= w_pend_nxt;
            r_overflow <= w_ovf_nxt;
            r_level    <= (w_state_nxt == ST_HOLD);
        end
    end

    assign level_out = r_level;
    assign busy      = (r_state != ST_IDLE);
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: a cycle model pushes expected
// outputs into a scoreboard queue, popped and compared after each edge.
module tb_pulse_stretcher;

    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int PMAX = 7;

    typedef struct packed {
        logic       lvl;
        logic       bsy;
        logic [2:0] pend;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       pulse_in;
    logic       clear_ovf;
    logic       level_out;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    int vectors   = 0;
    int miscompares = 0;

    // Model state: phase 0=idle 1=hold 2=gap, cnt = 1-based cycle within phase.
    int m_phase = 0;
    int m_cnt   = 0;
    int m_pend  = 0;
    bit m_ovf   = 1'b0;

    exp_t sb[$];

    pulse_stretcher #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .PEND_MAX   (PMAX),
        .PEND_W     (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .clear_ovf(clear_ovf),
        .level_out(level_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_edge(input bit p, input bit c, input bit r);
        bit launch;
        int t;
        if (r) begin
            m_phase = 0; m_cnt = 0; m_pend = 0; m_ovf = 1'b0;
        end else begin
            launch = ((m_phase == 0) || (m_phase == 2 && m_cnt == GAP)) && (p || m_pend > 0);
            t = m_pend + int'(p) - int'(launch);
            if (t > PMAX) begin
                t = PMAX;
                m_ovf = 1'b1;
            end else if (c) begin
                m_ovf = 1'b0;
            end
            m_pend = t;
            if (launch) begin
                m_phase = 1; m_cnt = 1;
            end else if (m_phase == 1) begin
                if (m_cnt == HOLD) begin m_phase = 2; m_cnt = 1; end
                else m_cnt++;
            end else if (m_phase == 2) begin
                if (m_cnt == GAP) begin m_phase = 0; m_cnt = 0; end
                else m_cnt++;
            end
        end
    endtask

    task automatic step(input bit p, input bit c, input bit r);
        exp_t e;
        exp_t got;
        @(negedge clk);
        pulse_in = p; clear_ovf = c; reset = r;
        model_edge(p, c, r);
        e.lvl = (m_phase == 1); e.bsy = (m_phase != 0);
        e.pend = 3'(m_pend); e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("level_out", int'(level_out), int'(got.lvl));
        chk("busy",      int'(busy),      int'(got.bsy));
        chk("pending",   int'(pending),   int'(got.pend));
        chk("overflow",  int'(overflow),  int'(got.ovf));
    endtask

    initial begin
        int guard;
        pulse_in = 1'b0; clear_ovf = 1'b0; reset = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1'b1);
        chk("reset_level", int'(level_out), 0);
        chk("reset_pend",  int'(pending),   0);
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Single event: 4 high cycles, busy through the gap.
        step(1'b1, 1'b0, 1'b0);
        chk("single_lvl_first", int'(level_out), 1);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("single_lvl_low", int'(level_out), 0);
        chk("single_busy_gap", int'(busy), 1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        chk("single_idle", int'(busy), 0);

        // Three back-to-back events queue up.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk("burst3_pend", int'(pending), 2);
        repeat (18) step(1'b0, 1'b0, 1'b0);
        chk("burst3_drained", int'(pending), 0);

        // Event on the last GAP cycle relaunches without IDLE.
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("gap_relaunch_lvl", int'(level_out), 1);
        chk("gap_relaunch_busy", int'(busy), 1);
        repeat (8) step(1'b0, 1'b0, 1'b0);

        // Held high for 20 cycles: saturation and overflow; clear on a drop loses.
        repeat (19) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("sat_pend", int'(pending), 7);
        chk("sat_ovf_clear_vs_drop", int'(overflow), 1);

        // Drain to pending=3 in the 2nd HOLD cycle, then reset there.
        guard = 0;
        while (!(m_phase == 1 && m_cnt == 2 && m_pend == 3) && guard < 100) begin
            step(1'b0, 1'b0, 1'b0);
            guard++;
        end
        chk("reach_hold2_pend3", int'(guard < 100), 1);
        chk("pre_reset_ovf", int'(overflow), 1);
        step(1'b1, 1'b1, 1'b1);
        chk("midhold_reset_lvl",  int'(level_out), 0);
        chk("midhold_reset_busy", int'(busy), 0);
        chk("midhold_reset_pend", int'(pending), 0);
        chk("midhold_reset_ovf",  int'(overflow), 0);

        // Re-set overflow, then clear_ovf alone clears it.
        repeat (15) step(1'b1, 1'b0, 1'b0);
        chk("ovf_set_again", int'(overflow), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("ovf_cleared", int'(overflow), 0);
        repeat (50) step(1'b0, 1'b0, 1'b0);
        chk("final_idle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
